// File: rtl/sdram_port_arbiter_if.sv
// Bundles the requester-side and SDRAM-side signals of sdram_port_arbiter.
// Latency: none. This is only wiring. The arbiter defines the timing.
// Backpressure: sd_ready_i gates gnt_o. A requester holds its fields until gnt_o.
interface sdram_port_arbiter_if #(
  parameter int NUM_PORTS = 4
);
  logic [NUM_PORTS-1:0]    req_i;
  logic [NUM_PORTS-1:0]    we_i;
  logic [NUM_PORTS*25-1:0] addr_i;
  logic [NUM_PORTS*16-1:0] wdata_i;
  logic [NUM_PORTS-1:0]    gnt_o;
  logic [NUM_PORTS-1:0]    rvalid_o;
  logic [15:0]             rdata_o;
  logic                    rlast_o;
  logic                    err_o;
  logic                    sd_ready_i;
  logic                    sd_valid_i;
  logic [15:0]             sd_data_i;
  logic                    sd_write_o;
  logic                    sd_read_o;
  logic [24:0]             sd_addr_o;
  logic [15:0]             sd_wdata_o;

  // Arbiter side
  modport slave (
    input  req_i, we_i, addr_i, wdata_i, sd_ready_i, sd_valid_i, sd_data_i,
    output gnt_o, rvalid_o, rdata_o, rlast_o, err_o,
    output sd_write_o, sd_read_o, sd_addr_o, sd_wdata_o
  );

  // Requester / SDRAM controller side
  modport master (
    output req_i, we_i, addr_i, wdata_i, sd_ready_i, sd_valid_i, sd_data_i,
    input  gnt_o, rvalid_o, rdata_o, rlast_o, err_o,
    input  sd_write_o, sd_read_o, sd_addr_o, sd_wdata_o
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM command channel, with in-order read-return routing.
// Latency: issue is combinational, req_i to gnt_o/sd_*_o. Read beats are registered, 1 cycle.
// Backpressure: no grant while sd_ready_i=0. Reads stall while the tag FIFO is full; writes still pass.
// Option: define SDRAM_ARB_PORT0_PRIO_EN to make port 0 strict priority over a ring of ports 1..N-1.
module sdram_port_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int BURST_LENGTH = 4,
  parameter int TAG_DEPTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sdram_port_arbiter_if.slave  bus
);
  localparam int TW = $clog2(NUM_PORTS);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
`ifdef SDRAM_ARB_PORT0_PRIO_EN
  // Port 0 sits outside the rotation, so the pointer starts on port 1.
  localparam logic [TW-1:0] RR_RST = TW'(1);
`else
  localparam logic [TW-1:0] RR_RST = '0;
`endif

  logic [TW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]        tag_mem_q [TAG_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        beat_cnt_q;
  logic [NUM_PORTS-1:0] rvalid_q;
  logic [15:0]          rdata_q;
  logic                 rlast_q, err_q;

  logic [NUM_PORTS-1:0] elig;
  logic [TW-1:0]        winner, idx, head;
  logic                 found, accept, push, pop, full, empty, beat_ok, beat_last;

  assign full      = (cnt_q == CW'(TAG_DEPTH));
  assign empty     = (cnt_q == '0);
  assign elig      = bus.req_i & (bus.we_i | {NUM_PORTS{~full}});
  // Reset also masks the combinational issue path, so every output is quiet while rst_n is low.
  assign accept    = rst_n & bus.sd_ready_i & found;
  assign push      = accept & ~bus.we_i[winner];
  assign head      = tag_mem_q[rd_ptr_q];
  assign beat_ok   = bus.sd_valid_i & ~empty;
  assign beat_last = (beat_cnt_q == BW'(BURST_LENGTH - 1));
  assign pop       = beat_ok & beat_last;

  // Winner search upward from rr_ptr, and the pointer advance on accept
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    idx      = '0;
    rr_ptr_d = rr_ptr_q;
`ifdef SDRAM_ARB_PORT0_PRIO_EN
    if (elig[0]) begin
      found = 1'b1;
    end else begin
      for (int i = 0; i < NUM_PORTS - 1; i++) begin
        idx = TW'(1 + ((int'(rr_ptr_q) - 1 + i) % (NUM_PORTS - 1)));
        if (!found && elig[idx]) begin
          found  = 1'b1;
          winner = idx;
        end
      end
    end
    if (rst_n && bus.sd_ready_i && found && winner != '0)
      rr_ptr_d = (winner == TW'(NUM_PORTS - 1)) ? TW'(1) : winner + TW'(1);
`else
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = TW'((int'(rr_ptr_q) + i) % NUM_PORTS);
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    if (rst_n && bus.sd_ready_i && found)
      rr_ptr_d = TW'((int'(winner) + 1) % NUM_PORTS);
`endif
  end

  // Command channel: the grant plus the winner's fields, all zero when nothing is accepted
  always_comb begin
    bus.gnt_o      = '0;
    bus.sd_write_o = 1'b0;
    bus.sd_read_o  = 1'b0;
    bus.sd_addr_o  = '0;
    bus.sd_wdata_o = '0;
    if (accept) begin
      bus.gnt_o[winner] = 1'b1;
      bus.sd_write_o    = bus.we_i[winner];
      bus.sd_read_o     = ~bus.we_i[winner];
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (winner == TW'(k)) begin
          bus.sd_addr_o  = bus.addr_i[k*25 +: 25];
          bus.sd_wdata_o = bus.wdata_i[k*16 +: 16];
        end
      end
    end
  end

  // Tag FIFO occupancy. A simultaneous push and pop cancel out.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Tag storage holds no state that needs a reset value; the pointers define validity
  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_ptr_q] <= winner;
  end

  // Pointers, beat counter, registered return path and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= RR_RST;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      beat_cnt_q <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      rlast_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (beat_ok) beat_cnt_q <= beat_last ? '0 : beat_cnt_q + BW'(1);
      rvalid_q <= beat_ok ? (NUM_PORTS'(1) << head) : '0;
      rdata_q  <= beat_ok ? bus.sd_data_i : '0;
      rlast_q  <= pop;
      // A beat with no outstanding tag is dropped and flagged until reset
      if (bus.sd_valid_i && empty) err_q <= 1'b1;
    end
  end

  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.rlast_o  = rlast_q;
  assign bus.err_o    = err_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: 4 ports, burst 4, 2-entry tag FIFO.
// Inputs change 1 ns after a rising edge. Combinational outputs are sampled 2 ns later.
// Registered outputs are sampled 1 ns after the edge that loads them.
module tb_sdram_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  logic [24:0] exp_addr;

  sdram_port_arbiter_if #(.NUM_PORTS(4)) bus ();

  sdram_port_arbiter #(
    .NUM_PORTS(4),
    .BURST_LENGTH(4),
    .TAG_DEPTH(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int k, input logic [24:0] a, input logic [15:0] d);
    bus.addr_i[k*25 +: 25]  = a;
    bus.wdata_i[k*16 +: 16] = d;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.req_i      = 4'b1111;
    bus.we_i       = 4'b1111;
    bus.sd_ready_i = 1'b1;
    bus.sd_valid_i = 1'b0;
    bus.sd_data_i  = '0;
    for (int k = 0; k < 4; k++) set_port(k, 25'h0ABC00 + 25'(k), 16'hA000 + 16'(k));

    // Reset state, with requests present: reset masks the issue path
    #3;
    chk("rst_gnt",    32'(bus.gnt_o),      32'h0);
    chk("rst_write",  32'(bus.sd_write_o), 32'h0);
    chk("rst_addr",   32'(bus.sd_addr_o),  32'h0);
    chk("rst_rvalid", 32'(bus.rvalid_o),   32'h0);
    chk("rst_rdata",  32'(bus.rdata_o),    32'h0);
    chk("rst_rlast",  32'(bus.rlast_o),    32'h0);
    chk("rst_err",    32'(bus.err_o),      32'h0);
    bus.req_i = 4'b0000;
    step();
    rst_n = 1'b1;

    // Fairness: all four ports write, grants rotate 0,1,2,3,0,1
    bus.req_i = 4'b1111;
    bus.we_i  = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #2;
      exp_addr = 25'h0ABC00 + 25'(c % 4);
      chk($sformatf("fair_gnt%0d", c),   32'(bus.gnt_o),      32'(1 << (c % 4)));
      chk($sformatf("fair_write%0d", c), 32'(bus.sd_write_o), 32'h1);
      chk($sformatf("fair_read%0d", c),  32'(bus.sd_read_o),  32'h0);
      chk($sformatf("fair_addr%0d", c),  32'(bus.sd_addr_o),  32'(exp_addr));
      step();
    end

    // Backpressure: port 2 waits through 5 not-ready cycles
    bus.req_i      = 4'b0100;
    bus.sd_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #2;
      chk($sformatf("bp_gnt%0d", c),  32'(bus.gnt_o),      32'h0);
      chk($sformatf("bp_wr%0d", c),   32'(bus.sd_write_o), 32'h0);
      chk($sformatf("bp_addr%0d", c), 32'(bus.sd_addr_o),  32'h0);
      step();
    end
    bus.sd_ready_i = 1'b1;
    #2;
    chk("bp_release_gnt",   32'(bus.gnt_o),      32'h4);
    chk("bp_release_wdata", 32'(bus.sd_wdata_o), 32'hA002);
    step();

    // Idle: nothing requested, command fields are zero
    bus.req_i = 4'b0000;
    #2;
    chk("idle_wdata", 32'(bus.sd_wdata_o), 32'h0);
    chk("idle_read",  32'(bus.sd_read_o),  32'h0);
    step();

    // Read routing: port 1 then port 3, followed by 8 beats
    set_port(1, 25'h0000100, 16'h0);
    set_port(3, 25'h1000000, 16'h0);
    bus.we_i  = 4'b0000;
    bus.req_i = 4'b0010;
    #2;
    chk("rd1_gnt",  32'(bus.gnt_o),      32'h2);
    chk("rd1_read", 32'(bus.sd_read_o),  32'h1);
    chk("rd1_wr",   32'(bus.sd_write_o), 32'h0);
    chk("rd1_addr", 32'(bus.sd_addr_o),  32'h0000100);
    step();
    bus.req_i = 4'b1000;
    #2;
    chk("rd3_gnt",  32'(bus.gnt_o),     32'h8);
    chk("rd3_addr", 32'(bus.sd_addr_o), 32'h1000000);
    step();
    bus.req_i = 4'b0000;
    for (int b = 0; b < 8; b++) begin
      bus.sd_valid_i = 1'b1;
      bus.sd_data_i  = 16'h0011 + 16'(b);
      step();
      chk($sformatf("route_rvalid%0d", b), 32'(bus.rvalid_o), (b < 4) ? 32'h2 : 32'h8);
      chk($sformatf("route_rdata%0d", b),  32'(bus.rdata_o),  32'h11 + 32'(b));
      chk($sformatf("route_rlast%0d", b),  32'(bus.rlast_o),  (b % 4 == 3) ? 32'h1 : 32'h0);
    end
    bus.sd_valid_i = 1'b0;
    step();
    chk("route_quiet", 32'(bus.rvalid_o), 32'h0);
    chk("route_err",   32'(bus.err_o),    32'h0);

    // Tag full: two reads fill the FIFO; a port 0 read stalls, a port 2 write passes
    bus.req_i = 4'b0010;
    #2;
    chk("full_rd1_gnt", 32'(bus.gnt_o), 32'h2);
    step();
    bus.req_i = 4'b1000;
    #2;
    chk("full_rd3_gnt", 32'(bus.gnt_o), 32'h8);
    step();
    bus.req_i = 4'b0101;
    bus.we_i  = 4'b0100;
    #2;
    chk("full_wr2_gnt", 32'(bus.gnt_o),      32'h4);
    chk("full_wr2_wr",  32'(bus.sd_write_o), 32'h1);
    step();
    bus.req_i = 4'b0001;
    bus.we_i  = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      bus.sd_valid_i = 1'b1;
      bus.sd_data_i  = 16'h0020 + 16'(b);
      #2;
      chk($sformatf("full_stall%0d", b), 32'(bus.gnt_o), 32'h0);
      step();
      chk($sformatf("full_rvalid%0d", b), 32'(bus.rvalid_o), 32'h2);
    end
    chk("full_rlast", 32'(bus.rlast_o), 32'h1);
    bus.sd_valid_i = 1'b0;
    #2;
    chk("full_rd0_gnt",  32'(bus.gnt_o),     32'h1);
    chk("full_rd0_read", 32'(bus.sd_read_o), 32'h1);
    chk("full_rd0_addr", 32'(bus.sd_addr_o), 32'h0ABC00);
    step();
    bus.req_i = 4'b0000;
    for (int b = 0; b < 8; b++) begin
      bus.sd_valid_i = 1'b1;
      bus.sd_data_i  = 16'h0030 + 16'(b);
      step();
      chk($sformatf("drain_rvalid%0d", b), 32'(bus.rvalid_o), (b < 4) ? 32'h8 : 32'h1);
    end

    // Error: beat with no outstanding read is dropped and err_o sticks
    bus.sd_data_i = 16'h0055;
    step();
    chk("err_rvalid", 32'(bus.rvalid_o), 32'h0);
    chk("err_set",    32'(bus.err_o),    32'h1);
    bus.sd_valid_i = 1'b0;
    step();
    chk("err_sticky", 32'(bus.err_o), 32'h1);

    // Reset mid-burst: one beat of a port 2 read delivered, then rst_n drops
    bus.req_i = 4'b0100;
    #2;
    chk("mid_gnt", 32'(bus.gnt_o), 32'h4);
    step();
    bus.req_i      = 4'b0000;
    bus.sd_valid_i = 1'b1;
    bus.sd_data_i  = 16'h0066;
    step();
    chk("mid_rvalid", 32'(bus.rvalid_o), 32'h4);
    chk("mid_rdata",  32'(bus.rdata_o),  32'h66);
    bus.sd_valid_i = 1'b0;
    bus.req_i      = 4'b0010;
    bus.we_i       = 4'b0010;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rvalid", 32'(bus.rvalid_o),   32'h0);
    chk("arst_rdata",  32'(bus.rdata_o),    32'h0);
    chk("arst_err",    32'(bus.err_o),      32'h0);
    chk("arst_gnt",    32'(bus.gnt_o),      32'h0);
    chk("arst_write",  32'(bus.sd_write_o), 32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_gnt", 32'(bus.gnt_o), 32'h2);
    bus.req_i = 4'b0000;
    step();
    bus.sd_valid_i = 1'b1;
    bus.sd_data_i  = 16'h0077;
    step();
    chk("stray_rvalid", 32'(bus.rvalid_o), 32'h0);
    chk("stray_err",    32'(bus.err_o),    32'h1);
    bus.sd_valid_i = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
